// File: rtl/forward_operand_unit_pkg.sv
// Shared constants for the EX-stage operand forwarding and load-use stall unit.
package forward_operand_unit_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_IMM = 2'b11;

  localparam int STALL_CNT_W = 3;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } stall_state_e;

endpackage

// File: rtl/fwd_select.sv
// Compare-and-mux for one ALU operand: picks the register file, WB, MEM or immediate source.
module fwd_select
  import forward_operand_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              use_imm,
  input  logic [REG_AW-1:0] src_reg,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] reg_data,
  input  logic [DATA_W-1:0] imm_data,
  output logic [1:0]        fwd_code,
  output logic [DATA_W-1:0] operand
);

  logic mem_hit;
  logic wb_hit;

  // r0 is hard-wired zero, so a write to it must never be forwarded
  assign mem_hit = mem_reg_write && (mem_rd != '0) && (mem_rd == src_reg);
  assign wb_hit  = wb_reg_write && (wb_rd != '0) && (wb_rd == src_reg);

  always_comb begin
    fwd_code = FWD_REG;
    if (use_imm) begin
      fwd_code = FWD_IMM;
    end else if (mem_hit) begin
      fwd_code = FWD_MEM;
    end else if (wb_hit) begin
      fwd_code = FWD_WB;
    end
  end

  always_comb begin
    operand = reg_data;
    unique case (fwd_code)
      FWD_REG: operand = reg_data;
      FWD_WB:  operand = wb_data;
      FWD_MEM: operand = mem_data;
      FWD_IMM: operand = imm_data;
    endcase
  end

endmodule

// File: rtl/forward_operand_unit.sv
// EX-stage operand forwarding with registered ALU operands, plus a load-use stall FSM
// that holds Stall/Bubble for LOAD_LAT cycles and keeps a saturating stall counter.
module forward_operand_unit
  import forward_operand_unit_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Hold,
  input  logic [REG_AW-1:0] ID_Rs,
  input  logic [REG_AW-1:0] ID_Rt,
  input  logic              EX_Valid,
  input  logic [REG_AW-1:0] EX_Rs,
  input  logic [REG_AW-1:0] EX_Rt,
  input  logic [REG_AW-1:0] EX_Rd,
  input  logic              EX_MemRead,
  input  logic              EX_UseImm,
  input  logic [DATA_W-1:0] EX_ReadData1,
  input  logic [DATA_W-1:0] EX_ReadData2,
  input  logic [DATA_W-1:0] EX_Imm,
  input  logic              MEM_RegWrite,
  input  logic [REG_AW-1:0] MEM_Rd,
  input  logic [DATA_W-1:0] MEM_ALUResult,
  input  logic              WB_RegWrite,
  input  logic [REG_AW-1:0] WB_Rd,
  input  logic [DATA_W-1:0] WB_WriteData,
  output logic [DATA_W-1:0] ALUInputA,
  output logic [DATA_W-1:0] ALUInputB,
  output logic              OperandValid,
  output logic [1:0]        ForwardA,
  output logic [1:0]        ForwardB,
  output logic              Stall,
  output logic              Bubble,
  output logic [CNT_W-1:0]  StallCount
);

  // The hazard cycle itself is the first stall cycle, so STALL covers the remaining LOAD_LAT-1
  localparam logic [STALL_CNT_W-1:0] LOAD_INIT =
    (LOAD_LAT > 1) ? STALL_CNT_W'(LOAD_LAT - 2) : '0;

  logic [REG_AW-1:0] src_reg  [2];
  logic [DATA_W-1:0] reg_data [2];
  logic              use_imm  [2];
  logic [1:0]        fwd_code [2];
  logic [DATA_W-1:0] operand  [2];

  assign src_reg[0]  = EX_Rs;
  assign src_reg[1]  = EX_Rt;
  assign reg_data[0] = EX_ReadData1;
  assign reg_data[1] = EX_ReadData2;
  assign use_imm[0]  = 1'b0;
  assign use_imm[1]  = EX_UseImm;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      fwd_select #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
      ) u_fwd_select (
        .use_imm       (use_imm[gi]),
        .src_reg       (src_reg[gi]),
        .mem_reg_write (MEM_RegWrite),
        .mem_rd        (MEM_Rd),
        .mem_data      (MEM_ALUResult),
        .wb_reg_write  (WB_RegWrite),
        .wb_rd         (WB_Rd),
        .wb_data       (WB_WriteData),
        .reg_data      (reg_data[gi]),
        .imm_data      (EX_Imm),
        .fwd_code      (fwd_code[gi]),
        .operand       (operand[gi])
      );
    end
  endgenerate

  logic [DATA_W-1:0] alu_a_reg;
  logic [DATA_W-1:0] alu_b_reg;
  logic [1:0]        fwd_a_reg;
  logic [1:0]        fwd_b_reg;
  logic              valid_reg;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      alu_a_reg <= '0;
      alu_b_reg <= '0;
      fwd_a_reg <= FWD_REG;
      fwd_b_reg <= FWD_REG;
      valid_reg <= 1'b0;
    end else if (!Hold) begin
      alu_a_reg <= operand[0];
      alu_b_reg <= operand[1];
      fwd_a_reg <= fwd_code[0];
      fwd_b_reg <= fwd_code[1];
      valid_reg <= EX_Valid;
    end
  end

  stall_state_e           state_reg;
  stall_state_e           state_next;
  logic [STALL_CNT_W-1:0] down_cnt_reg;
  logic [STALL_CNT_W-1:0] down_cnt_next;
  logic [CNT_W-1:0]       stall_count_reg;
  logic                   hazard;
  logic                   stall_comb;

  assign hazard = EX_MemRead && (EX_Rd != '0) && ((EX_Rd == ID_Rs) || (EX_Rd == ID_Rt));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg    <= RUN;
      down_cnt_reg <= '0;
    end else if (!Hold) begin
      state_reg    <= state_next;
      down_cnt_reg <= down_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    down_cnt_next = down_cnt_reg;
    stall_comb    = 1'b0;
    unique case (state_reg)
      RUN: begin
        if (hazard) begin
          stall_comb = 1'b1;
          if (LOAD_LAT > 1) begin
            state_next    = STALL;
            down_cnt_next = LOAD_INIT;
          end
        end
      end
      STALL: begin
        // hazard is deliberately not examined here so a stall cannot re-arm itself
        stall_comb = 1'b1;
        if (down_cnt_reg == '0) begin
          state_next = RUN;
        end else begin
          down_cnt_next = down_cnt_reg - 3'd1;
        end
      end
    endcase
    if (Reset) begin
      stall_comb = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_count_reg <= '0;
    end else if (!Hold && stall_comb && (stall_count_reg != '1)) begin
      stall_count_reg <= stall_count_reg + CNT_W'(1);
    end
  end

  assign ALUInputA    = alu_a_reg;
  assign ALUInputB    = alu_b_reg;
  assign ForwardA     = fwd_a_reg;
  assign ForwardB     = fwd_b_reg;
  assign OperandValid = valid_reg;
  assign Stall        = stall_comb;
  assign Bubble       = stall_comb;
  assign StallCount   = stall_count_reg;

endmodule

// File: doc/forward_operand_unit.md
FORWARD_OPERAND_UNIT -- requirements
Module: forward_operand_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: Clk clocks every flop, and Reset is sampled on the rising edge of Clk.
REQ-002 The block SHALL provide parameter DATA_W, default 32, as the operand width.
REQ-003 The block SHALL provide parameter REG_AW, default 5, as the register-address width.
REQ-004 The block SHALL provide parameter LOAD_LAT, default 1, range 1..7, as the number of stall cycles per load-use hazard.
REQ-005 The block SHALL provide parameter CNT_W, default 16, as the width of the stall statistics counter.
REQ-006 The block SHALL provide these ports (name, direction, width, meaning):
- Clk  in  1  clock
- Reset  in  1  synchronous active-high reset
- Hold  in  1  global pipeline freeze
- ID_Rs, ID_Rt  in  REG_AW  source registers of the instruction in ID
- EX_Valid  in  1  EX stage holds a real instruction
- EX_Rs, EX_Rt  in  REG_AW  source registers of the instruction in EX
- EX_Rd  in  REG_AW  destination register of the instruction in EX
- EX_MemRead  in  1  EX instruction is a load
- EX_UseImm  in  1  operand B takes the immediate
- EX_ReadData1, EX_ReadData2, EX_Imm  in  DATA_W  register-file data and sign-extended immediate
- MEM_RegWrite  in  1  MEM instruction writes a register
- MEM_Rd  in  REG_AW  MEM destination register
- MEM_ALUResult  in  DATA_W  MEM ALU result
- WB_RegWrite  in  1  WB instruction writes a register
- WB_Rd  in  REG_AW  WB destination register
- WB_WriteData  in  DATA_W  WB write-back data
- ALUInputA, ALUInputB  out  DATA_W  registered ALU operands
- OperandValid  out  1  operands are valid
- ForwardA, ForwardB  out  2  registered select codes
- Stall  out  1  hold the PC and IF/ID
- Bubble  out  1  zero the ID/EX register
- StallCount  out  CNT_W  count of stall cycles

Function
REQ-007 The operand-A select code SHALL be: 2'b10 if MEM_RegWrite is 1, MEM_Rd is nonzero and MEM_Rd equals EX_Rs; else 2'b01 if WB_RegWrite is 1, WB_Rd is nonzero and WB_Rd equals EX_Rs; else 2'b00.
REQ-008 The operand-B select code SHALL use the same rule as REQ-007 with EX_Rt in place of EX_Rs.
REQ-009 When EX_UseImm is 1, the operand-B select code SHALL be 2'b11 and EX_Imm SHALL be selected, overriding any forwarding.
REQ-010 The data selected for each select code SHALL be: 00 selects ReadData, 01 selects WB_WriteData, 10 selects MEM_ALUResult, 11 selects EX_Imm.
REQ-011 Register 0 SHALL never be forwarded.
REQ-012 ALUInputA, ALUInputB, ForwardA, ForwardB and OperandValid SHALL be registered with 1-cycle latency; OperandValid SHALL be loaded from EX_Valid.
REQ-013 When Hold is 1, all registered outputs, the FSM state, the down-counter and StallCount SHALL keep their values.
REQ-014 A load-use hazard SHALL be detected when EX_MemRead is 1, EX_Rd is nonzero and EX_Rd equals ID_Rs or ID_Rt.
REQ-015 The stall FSM SHALL have two states, RUN and STALL, with a down-counter 3 bits wide.
REQ-016 In RUN with a hazard: Stall and Bubble SHALL be 1 combinationally in the same cycle; if LOAD_LAT is greater than 1 the FSM SHALL move to STALL with the counter set to LOAD_LAT-2, otherwise it SHALL stay in RUN.
REQ-017 In STALL: Stall and Bubble SHALL be 1; the FSM SHALL return to RUN when the counter is 0, and otherwise decrement the counter.
REQ-018 Hazard detection SHALL be ignored while in STALL, so no re-trigger occurs mid-stall.
REQ-019 In total, Stall SHALL be high for exactly LOAD_LAT consecutive non-Hold cycles per hazard.
REQ-020 Stall and Bubble SHALL be 0 whenever Reset is 1.
REQ-021 StallCount SHALL increment on every non-Hold cycle in which Stall is 1 and SHALL saturate at all-ones, with no wrap-around.
REQ-022 If a hazard and Hold are both 1 in the same cycle, Stall SHALL still be asserted, but the FSM SHALL not advance until Hold is 0.

Reset
REQ-023 When Reset is sampled at 1, ALUInputA, ALUInputB, ForwardA, ForwardB, OperandValid and StallCount SHALL be 0, the FSM SHALL be in RUN and the counter SHALL be 0.
REQ-024 Reset SHALL take priority over Hold.
REQ-025 Reset asserted during STALL SHALL abort the stall, with Stall equal to 0 in the cycle after Reset is released (absent a new hazard).

Structure
REQ-026 A shared package SHALL hold the forward-code constants FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10 and FWD_IMM=2'b11, and the FSM state encoding (RUN, STALL).
REQ-027 One sub-module, fwd_select, SHALL implement the combinational compare-and-mux for a single operand and SHALL be instantiated twice, once for operand A and once for operand B.

Verification
REQ-028 The bench SHALL check MEM/WB priority: EX_Rs=5, MEM_Rd=5 with MEM_RegWrite=1 and MEM_ALUResult=0x11, WB_Rd=5 with WB_RegWrite=1 and WB_WriteData=0x22 -> next cycle ALUInputA=0x11 and ForwardA=10.
REQ-029 The bench SHALL check register 0 and immediate handling: EX_Rt=0, MEM_Rd=0, MEM_RegWrite=1, EX_ReadData2=0x7 -> ALUInputB=0x7 and ForwardB=00; then EX_UseImm=1 with EX_Imm=0xFFFFFFFC and MEM_Rd=EX_Rt=3 -> ALUInputB=0xFFFFFFFC and ForwardB=11.
REQ-030 The bench SHALL check the load-use stall at LOAD_LAT=3: EX_MemRead=1, EX_Rd=8, ID_Rt=8 for one cycle -> Stall and Bubble high for exactly 3 cycles, then StallCount=3.
REQ-031 The bench SHALL check Hold: Hold=1 for 4 cycles during STALL -> Stall remains high, the counter is frozen, StallCount does not change, and the stall completes after Hold drops.
REQ-032 The bench SHALL check saturation: with CNT_W=4, 20 back-to-back hazards at LOAD_LAT=1 -> StallCount stops at 15.
REQ-033 The bench SHALL check reset mid-stall: Reset=1 in the second STALL cycle -> all outputs are 0 the following cycle and the FSM is in RUN.
